// File: rtl/xtal_osc_32k_ctrl_pkg.sv
// Shared types and default constants for the 32.768 kHz crystal oscillator
// startup sequencer / health monitor.
package xtal_osc_32k_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BOOST  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4,
    ST_DEAD   = 3'd5
  } xo_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_BOOST_CYC   = 5000000;
  localparam int DEF_SETTLE_CYC  = 100000;
  localparam int DEF_EDGE_MIN    = 64;
  localparam int DEF_WDOG_CYC    = 1024;
  localparam int DEF_MAX_RETRY   = 3;

  // Width of the qualifying-edge counter used during SETTLE.
  localparam int EDGE_W = 16;

endpackage

// File: rtl/xtal_osc_32k_sync_edge.sv
// Synchronizer (SYNC_STAGES flops) plus rising-edge detector for an
// asynchronous 1-bit input. The rise pulse is one clk cycle wide.
module xtal_osc_32k_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_dly;

  // Shift the async input through the synchronizer, then delay one more cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync     <= '0;
      sync_dly <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], din};
      sync_dly <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_dly;

endmodule

// File: rtl/xtal_osc_32k_ctrl.sv
// Startup sequencer and health monitor for the 32.768 kHz crystal oscillator.
// Sequence: OFF -> BOOST -> SETTLE -> RUN, with FAIL/retry and a sticky DEAD.
// Optional frequency monitor: define XTAL_OSC_32K_CTRL_FREQ_MON_EN to add
// freq_cnt/freq_vld (clk cycles between consecutive dout rises while in RUN).
module xtal_osc_32k_ctrl
  import xtal_osc_32k_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BOOST_CYC   = DEF_BOOST_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int EDGE_MIN    = DEF_EDGE_MIN,
  parameter int WDOG_CYC    = DEF_WDOG_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        xo_dout,
  output logic        xo_ena,
  output logic        xo_boost,
  output logic        ready,
  output logic        fault,
  output logic [2:0]  retry_cnt
`ifdef XTAL_OSC_32K_CTRL_FREQ_MON_EN
  ,
  output logic [15:0] freq_cnt,
  output logic        freq_vld
`endif
);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  // Reject parameter sets the timer or retry counter cannot represent.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (MAX_RETRY < 0) || (MAX_RETRY > 7) ||
      (EDGE_MIN < 1) || (EDGE_MIN >= (1 << EDGE_W)) ||
      (BOOST_CYC < 1) || (longint'(BOOST_CYC) >= CNT_SPAN) ||
      (SETTLE_CYC < 1) || (longint'(SETTLE_CYC) >= CNT_SPAN) ||
      (WDOG_CYC < 1) || (longint'(WDOG_CYC) >= CNT_SPAN)) begin : g_param_err
    $error("xtal_osc_32k_ctrl: illegal parameter set");
  end

  localparam logic [CNT_W-1:0]  BOOST_LAST  = CNT_W'(BOOST_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  WDOG_LAST   = CNT_W'(WDOG_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_CAP    = EDGE_W'(EDGE_MIN);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(EDGE_MIN - 1);
  localparam logic [2:0]        RETRY_MAX   = 3'(MAX_RETRY);

  function automatic logic [EDGE_W-1:0] edge_sat_inc(input logic [EDGE_W-1:0] v);
    return (v >= EDGE_CAP) ? EDGE_CAP : v + EDGE_W'(1);
  endfunction

  xo_state_t         state, state_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic [EDGE_W-1:0] edge_cnt, edge_nxt;
  logic [2:0]        retry_nxt;
  logic              rise;

  xtal_osc_32k_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .resetn (resetn),
    .din    (xo_dout),
    .rise   (rise)
  );

  // Next-state, timer, edge-counter and retry decisions; req low always wins.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    edge_nxt  = edge_cnt;
    retry_nxt = retry_cnt;
    if (!req) begin
      state_nxt = ST_OFF;
      timer_nxt = '0;
      edge_nxt  = '0;
      retry_nxt = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          state_nxt = ST_BOOST;
          timer_nxt = '0;
          edge_nxt  = '0;
        end
        ST_BOOST: begin
          if (timer == BOOST_LAST) begin
            state_nxt = ST_SETTLE;
            timer_nxt = '0;
            edge_nxt  = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (rise) edge_nxt = edge_sat_inc(edge_cnt);
          // The qualifying edge takes priority over a coincident settle timeout.
          if (rise && (edge_cnt == EDGE_LAST)) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
          end else if (timer == SETTLE_LAST) begin
            state_nxt = ST_FAIL;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (rise) begin
            timer_nxt = '0;
          end else if (timer == WDOG_LAST) begin
            state_nxt = ST_FAIL;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CNT_W'(1);
          end
        end
        ST_FAIL: begin
          // One cycle with ena low power-cycles the oscillator before a retry.
          if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + 3'd1;
            state_nxt = ST_BOOST;
            timer_nxt = '0;
            edge_nxt  = '0;
          end else begin
            state_nxt = ST_DEAD;
          end
        end
        ST_DEAD: begin
          state_nxt = ST_DEAD;
        end
        default: begin
          state_nxt = ST_OFF;
          timer_nxt = '0;
          edge_nxt  = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // State, timer, edge counter and retry counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_OFF;
      timer     <= '0;
      edge_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      edge_cnt  <= edge_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xo_ena   <= 1'b0;
      xo_boost <= 1'b0;
      ready    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      xo_ena   <= (state_nxt == ST_BOOST) || (state_nxt == ST_SETTLE) ||
                  (state_nxt == ST_RUN);
      xo_boost <= (state_nxt == ST_BOOST);
      ready    <= (state_nxt == ST_RUN);
      fault    <= (state_nxt == ST_DEAD);
    end
  end

`ifdef XTAL_OSC_32K_CTRL_FREQ_MON_EN
  function automatic logic [15:0] per_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] per_cnt;

  // Period measurement between consecutive rises; cleared whenever not in RUN.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      per_cnt  <= '0;
      freq_cnt <= '0;
      freq_vld <= 1'b0;
    end else if (state_nxt != ST_RUN) begin
      per_cnt  <= '0;
      freq_cnt <= '0;
      freq_vld <= 1'b0;
    end else if (state != ST_RUN) begin
      // Entry edge: the qualifying rise starts the first period.
      per_cnt  <= '0;
      freq_vld <= 1'b0;
    end else if (rise) begin
      freq_cnt <= per_sat_inc(per_cnt);
      freq_vld <= 1'b1;
      per_cnt  <= '0;
    end else begin
      per_cnt  <= per_sat_inc(per_cnt);
      freq_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_xtal_osc_32k_ctrl.sv
// Self-checking bench for xtal_osc_32k_ctrl. Each request episode is turned
// into an expected per-cycle output timeline from the startup rules, pushed
// into a scoreboard as stimulus is applied, and checked by a monitor.
module tb_xtal_osc_32k_ctrl;

  localparam int S   = 2;
  localparam int B   = 100;
  localparam int SET = 200;
  localparam int EM  = 4;
  localparam int W   = 50;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req = 1'b0;
  logic xo_dout = 1'b0;
  logic xo_ena, xo_boost, ready, fault;
  logic [2:0] retry_cnt;
`ifdef XTAL_OSC_32K_CTRL_FREQ_MON_EN
  logic [15:0] freq_cnt;
  logic        freq_vld;
`endif

  xtal_osc_32k_ctrl #(
    .SYNC_STAGES (S),
    .CNT_W       (24),
    .BOOST_CYC   (B),
    .SETTLE_CYC  (SET),
    .EDGE_MIN    (EM),
    .WDOG_CYC    (W),
    .MAX_RETRY   (MR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .xo_dout   (xo_dout),
    .xo_ena    (xo_ena),
    .xo_boost  (xo_boost),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
`ifdef XTAL_OSC_32K_CTRL_FREQ_MON_EN
    ,
    .freq_cnt  (freq_cnt),
    .freq_vld  (freq_vld)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned n;
    logic [6:0]  ctl;
    logic [15:0] fc;
    logic        fv;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  // Episode stimulus and expected timeline (index = edge within episode).
  bit          ep_d[];
  bit          seen[];
  logic [6:0]  ec[];
  logic [15:0] ef[];
  bit          ev[];

  function automatic logic [6:0] pack(input bit f, input bit rd, input bit b,
                                      input bit e, input int rc);
    return {f, rd, b, e, rc[2:0]};
  endfunction

  task automatic note_fail(input string name, input int unsigned at,
                           input logic [15:0] got, input logic [15:0] req_v);
    fails++;
    if (fails <= 40)
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, at, got, req_v);
  endtask

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (sbq.size() > 0 && sbq[0].n <= cyc) begin
      e = sbq.pop_front();
      act = {fault, ready, xo_boost, xo_ena, retry_cnt};
      tests++;
      if (e.n != cyc) note_fail("sb_order", cyc, 16'(cyc), 16'(e.n));
      else if (act !== e.ctl) note_fail("ctl(fault,ready,boost,ena,retry)", cyc, 16'(act), 16'(e.ctl));
`ifdef XTAL_OSC_32K_CTRL_FREQ_MON_EN
      tests++;
      if ({freq_vld, freq_cnt} !== {e.fv, e.fc})
        note_fail("freq(vld,cnt)", cyc, {freq_vld, freq_cnt[14:0]}, {e.fv, e.fc[14:0]});
`endif
    end
  end

  task automatic drive(input logic rn, input logic rq, input logic dv,
                       input logic [6:0] ctl, input logic [15:0] fc, input logic fv);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn;
    req    = rq;
    xo_dout = dv;
    e.n = cyc + 1;
    e.ctl = ctl;
    e.fc = fc;
    e.fv = fv;
    sbq.push_back(e);
  endtask

  // Reference timeline: BOOST for B cycles, SETTLE until the EM-th observed
  // rise (or timeout), RUN until W cycles pass without a rise, then one FAIL
  // cycle and a retry, or DEAD once MR retries are spent.
  task automatic model(input int L);
    int t, s, r, q, f, cnt, hit, rt;
    logic [15:0] cur;
    bit go;
    seen = new[L+1];
    ec = new[L+1];
    ef = new[L+1];
    ev = new[L+1];
    for (int i = 0; i <= L; i++) begin
      ec[i] = '0;
      ef[i] = '0;
      ev[i] = 1'b0;
      seen[i] = 1'b0;
      if (i >= S) begin
        if (ep_d[i-S]) begin
          if (i - S == 0) seen[i] = 1'b1;
          else if (!ep_d[i-S-1]) seen[i] = 1'b1;
        end
      end
    end
    rt = 0;
    t = 0;
    go = 1'b1;
    while (go && t < L) begin
      for (int k = 0; k < B; k++)
        if (t + k < L) ec[t+k] = pack(0, 0, 1, 1, rt);
      s = t + B;
      cnt = 0;
      hit = -1;
      for (int n = s + 1; n <= s + SET && n <= L && hit < 0; n++) begin
        if (seen[n]) begin
          cnt++;
          if (cnt == EM) hit = n;
        end
      end
      f = (hit >= 0) ? hit : s + SET;
      for (int n = s; n < f && n < L; n++) ec[n] = pack(0, 0, 0, 1, rt);
      if (hit >= 0) begin
        r = hit;
        q = r;
        f = -1;
        cur = '0;
        for (int n = r; n < L && f < 0; n++) begin
          if (n > r && seen[n]) begin
            ev[n] = 1'b1;
            cur = 16'(n - q);
            q = n;
          end else if (n - q == W) begin
            f = n;
          end
          if (f < 0) begin
            ec[n] = pack(0, 1, 0, 1, rt);
            ef[n] = cur;
          end
        end
        if (f < 0) go = 1'b0;
      end
      if (go) begin
        if (f < L) ec[f] = pack(0, 0, 0, 0, rt);
        if (rt < MR) begin
          rt++;
          t = f + 1;
        end else begin
          for (int n = f + 1; n < L; n++) ec[n] = pack(1, 0, 0, 0, rt);
          go = 1'b0;
        end
      end
    end
  endtask

  task automatic gen_periodic(input int L, input int p, input int hi,
                              input int start, input int stop);
    ep_d = new[L+1];
    for (int i = 0; i <= L; i++)
      ep_d[i] = (i >= start) && (i < stop) && (((i - start) % p) < hi);
  endtask

  // Four short pulses whose last rise is observed at edge 300 + skew.
  task automatic gen_coincide(input int L, input int skew);
    ep_d = new[L+1];
    for (int i = 0; i <= L; i++) ep_d[i] = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) ep_d[300 - S - 30 + 10*k + skew + j] = 1'b1;
  endtask

  task automatic run_episode(input int L, input bit by_reset, input int gap);
    int rlen;
    model(L);
    for (int i = 0; i < L; i++) drive(1'b1, 1'b1, ep_d[i], ec[i], ef[i], ev[i]);
    if (by_reset) drive(1'b0, 1'b1, ep_d[L], 7'd0, 16'd0, 1'b0);
    else          drive(1'b1, 1'b0, ep_d[L], 7'd0, 16'd0, 1'b0);
    rlen = by_reset ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gap; g++)
      drive((g < rlen) ? 1'b0 : 1'b1, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout cyc=%0d got=running required=finished", cyc);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int L, mode, p, st, sp, dens;
    // Reset state.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0);

    // Nominal startup, then clock loss in RUN and a retry.
    gen_periodic(700, 20, 10, 10, 400);
    run_episode(700, 1'b0, 8);
    // No oscillation: three attempts then DEAD; req low clears it.
    gen_periodic(1000, 20, 10, 0, 0);
    run_episode(1000, 1'b0, 8);
    // 4th rise coincides with the final settle cycle (RUN), then one cycle late (FAIL).
    gen_coincide(420, 0);
    run_episode(420, 1'b0, 8);
    gen_coincide(420, 1);
    run_episode(420, 1'b0, 8);
    // Abort mid-BOOST.
    gen_periodic(40, 20, 10, 0, 40);
    run_episode(40, 1'b0, 8);
    // resetn during RUN.
    gen_periodic(250, 20, 10, 10, 250);
    run_episode(250, 1'b1, 8);
    // 25-cycle oscillator period.
    gen_periodic(500, 25, 12, 5, 500);
    run_episode(500, 1'b0, 8);

    // Randomized episodes.
    for (int ep = 0; ep < 20; ep++) begin
      L = int'($urandom_range(30, 1100));
      mode = int'($urandom_range(0, 3));
      if (mode == 0 || mode == 1) begin
        p = int'($urandom_range(4, (mode == 0) ? 40 : 70));
        st = int'($urandom_range(0, 150));
        sp = int'($urandom_range(st, L));
        gen_periodic(L, p, int'($urandom_range(1, p - 1)), st, sp);
      end else if (mode == 2) begin
        gen_periodic(L, 10, 5, 0, 0);
      end else begin
        dens = int'($urandom_range(10, 60));
        ep_d = new[L+1];
        for (int i = 0; i <= L; i++) ep_d[i] = ($urandom_range(0, 99) < dens);
      end
      run_episode(L, ($urandom_range(0, 2) == 0), int'($urandom_range(5, 15)));
    end

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sbq.size() != 0) note_fail("sb_drain", cyc, 16'(sbq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
